// File: rtl/fetch_unit.sv
// fetch_unit: reads the PC, fetches over a req/ack port and hands the word to decode.
// Handles redirect flushes, misaligned PCs and memory-response timeouts.
module fetch_unit #(
  parameter logic [31:0] RESET_INSTR    = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] count;
  logic [7:0] count_inc;
  logic       misal;
  logic       timeout;

  assign misal     = pc_in[1:0] != 2'b00;
  // >= so a flush landing on the last REQ cycle still times out in DROP
  assign timeout   = count >= TO_LAST;
  assign count_inc = (count == 8'hFF) ? count : count + 8'd1;
  assign pc_en     = reset & instr_valid & instr_ready & ~flush;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = misal ? HOLD : REQ;
      REQ: begin
        if (flush) begin
          state_nxt = mem_ack ? IDLE : DROP;
        end else if (mem_ack || timeout) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (flush || pc_en) begin
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (mem_ack || timeout) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= RESET_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      count       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (misal) begin
            instr_valid <= 1'b1;
            fetch_fault <= 1'b1;
            instr       <= RESET_INSTR;
            instr_pc    <= pc_in;
          end else begin
            mem_req  <= 1'b1;
            mem_addr <= pc_in;
            count    <= '0;
          end
        end
        REQ: begin
          count <= count_inc;
          // an outstanding request is never withdrawn by a flush
          if (mem_ack || (timeout && !flush)) begin
            mem_req <= 1'b0;
          end
          if (!flush && (mem_ack || timeout)) begin
            instr_valid <= 1'b1;
            fetch_fault <= ~mem_ack;
            instr       <= mem_ack ? mem_rdata : RESET_INSTR;
            instr_pc    <= mem_addr;
          end
        end
        HOLD: begin
          if (flush || pc_en) begin
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            instr       <= RESET_INSTR;
          end
        end
        DROP: begin
          count <= count_inc;
          if (mem_ack || timeout) begin
            mem_req <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a PC model and a req/ack memory.
// A second instance with a short timeout covers the timeout fault.
module tb_fetch_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, flush, mem_ack, instr_ready;
  logic        pc_en, mem_req, instr_valid, fetch_fault;
  logic [31:0] pc_in, mem_addr, mem_rdata, instr, instr_pc;

  logic        reset2, flush2, ack2, ready2;
  logic        pc_en2, req2, valid2, fault2;
  logic [31:0] pc2, addr2, rdata2, instr2, ipc2;

  fetch_unit dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_en(pc_en),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  fetch_unit #(.TIMEOUT_CYCLES(4)) dut_to (
    .clock(clock), .reset(reset2), .pc_in(pc2), .pc_en(pc_en2),
    .flush(flush2), .mem_req(req2), .mem_addr(addr2),
    .mem_ack(ack2), .mem_rdata(rdata2), .instr(instr2),
    .instr_pc(ipc2), .instr_valid(valid2),
    .instr_ready(ready2), .fetch_fault(fault2)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   ack_delay;
  int   wait_cnt;
  logic mem_en;
  logic use_bad;

  function automatic logic [31:0] word_at(logic [31:0] a);
    return 32'h0050_0093 + (a - 32'h100);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic expect_fetch(logic [31:0] pc, logic fault);
    exp_t e;
    e.instr = fault ? 32'h0000_0013 : word_at(pc);
    e.pc    = pc;
    e.fault = fault;
    sb.push_back(e);
  endtask

  // one cycle; the PC register advances on edges where pc_en was high
  task automatic tick();
    logic adv;
    @(negedge clock);
    adv = pc_en;
    @(posedge clock);
    #1;
    if (adv) pc_in = pc_in + 32'd4;
  endtask

  task automatic wait_drain(string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_req(string tag);
    int n = 0;
    while (!mem_req && n < 40) begin
      tick();
      n++;
    end
    chk(tag, 32'(mem_req), 32'd1);
  endtask

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      mem_ack = 1'b0;
      if (mem_req && mem_en) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = use_bad ? 32'hDEAD_BEEF : word_at(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (reset && instr_valid && instr_ready && !flush) begin
        chk("handoff_pc_en", 32'(pc_en), 32'd1);
        if (sb.size() == 0) begin
          chk("unexpected_instr_pc", instr_pc, 32'hFFFF_FFFF);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_instr", instr, mon_e.instr);
          chk("sb_instr_pc", instr_pc, mon_e.pc);
          chk("sb_fault", 32'(fetch_fault), 32'(mon_e.fault));
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0; flush = 1'b0; instr_ready = 1'b0; pc_in = 32'h100;
    mem_en = 1'b0; use_bad = 1'b0; ack_delay = 2;
    reset2 = 1'b0; flush2 = 1'b0; ack2 = 1'b0; rdata2 = '0;
    ready2 = 1'b0; pc2 = 32'h40;
    tick();
    tick();

    reset = 1'b1;
    wait_req("t1_req");
    tick();
    reset = 1'b0;
    instr_ready = 1'b1;
    tick(); tick(); tick();
    chk("t1_mem_req", 32'(mem_req), 32'd0);
    chk("t1_mem_addr", mem_addr, 32'd0);
    chk("t1_instr", instr, 32'h0000_0013);
    chk("t1_instr_pc", instr_pc, 32'd0);
    chk("t1_valid", 32'(instr_valid), 32'd0);
    chk("t1_fault", 32'(fetch_fault), 32'd0);
    chk("t1_pc_en", 32'(pc_en), 32'd0);

    pc_in = 32'h100; mem_en = 1'b1; ack_delay = 2;
    expect_fetch(32'h100, 1'b0);
    reset = 1'b1;
    wait_drain("t2_drain");
    chk("t2_valid_drop", 32'(instr_valid), 32'd0);
    chk("t2_pc_en_pulse", 32'(pc_en), 32'd0);
    tick();
    chk("t2_req_latency", 32'(mem_req), 32'd1);
    chk("t2_next_addr", mem_addr, 32'h104);

    instr_ready = 1'b0;
    expect_fetch(32'h104, 1'b0);
    n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t3_valid", 32'(instr_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_instr", instr, word_at(32'h104));
      chk("t3_instr_pc", instr_pc, 32'h104);
      chk("t3_pc_en", 32'(pc_en), 32'd0);
    end
    instr_ready = 1'b1;
    wait_drain("t3_drain");

    mem_en = 1'b0;
    wait_req("t4_req");
    chk("t4_addr", mem_addr, 32'h108);
    flush = 1'b1;
    pc_in = 32'h200;
    tick();
    flush = 1'b0;
    chk("t4_req_held", 32'(mem_req), 32'd1);
    use_bad = 1'b1; mem_en = 1'b1; ack_delay = 2;
    n = 0;
    while (mem_req && n < 40) begin
      tick();
      n++;
    end
    chk("t4_drop_done", 32'(mem_req), 32'd0);
    chk("t4_no_valid", 32'(instr_valid), 32'd0);
    use_bad = 1'b0;
    expect_fetch(32'h200, 1'b0);
    tick();
    chk("t4_req2", 32'(mem_req), 32'd1);
    chk("t4_addr2", mem_addr, 32'h200);
    wait_drain("t4_drain");

    reset = 1'b0;
    pc_in = 32'h102;
    instr_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    expect_fetch(32'h102, 1'b1);
    tick();
    chk("t5_no_req", 32'(mem_req), 32'd0);
    chk("t5_valid", 32'(instr_valid), 32'd1);
    chk("t5_fault", 32'(fetch_fault), 32'd1);
    chk("t5_instr", instr, 32'h0000_0013);
    chk("t5_instr_pc", instr_pc, 32'h102);
    instr_ready = 1'b1;
    wait_drain("t5_drain");
    instr_ready = 1'b0;
    tick();
    chk("t5_fault2", 32'(fetch_fault), 32'd1);
    chk("t5_instr_pc2", instr_pc, 32'h106);
    flush = 1'b1;
    instr_ready = 1'b1;
    pc_in = 32'h300;
    #1;
    chk("t5_flush_pc_en", 32'(pc_en), 32'd0);
    tick();
    flush = 1'b0;
    chk("t5_flush_valid", 32'(instr_valid), 32'd0);
    chk("t5_flush_fault", 32'(fetch_fault), 32'd0);
    ack_delay = 0;
    expect_fetch(32'h300, 1'b0);
    wait_drain("t5_drain2");
    instr_ready = 1'b0;

    reset2 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t6_req", 32'(req2), 32'd1);
      tick();
    end
    chk("t6_req_drop", 32'(req2), 32'd0);
    chk("t6_valid", 32'(valid2), 32'd1);
    chk("t6_fault", 32'(fault2), 32'd1);
    chk("t6_instr", instr2, 32'h0000_0013);
    chk("t6_instr_pc", ipc2, 32'h40);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
